// File: rtl/pipearch_dma_write_arbiter.sv
// pipearch_dma_write_arbiter
//   Shares one pipearch_dma_write engine among NUM_REQ requesters. Requests
//   are arbitrated round-robin and only one transfer is in flight at a time.
//   The arbiter starts the engine, routes the owner's write beats to it,
//   routes the engine's write acks and back-pressure back to the owner, and
//   turns the engine's done into a per-requester completion pulse.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset (shared with engine)
//   req_valid       per-requester request, held until its grant pulse
//   req_addr/len    per-requester base line address / length in lines,
//                   requester i packed at [i*W +: W]
//   req_grant       one-cycle grant pulse (coincides with dma_start)
//   req_we/wdata    per-requester write beat strobe / data
//   req_wvalid      write ack forwarded to the owner
//   req_almfull     back-pressure; non-owners are held off during a transfer
//   req_done        one-cycle completion pulse to the owner
//   err_overrun     sticky: owner sent a beat beyond the granted length
//   dma_*           engine control, tx_write and rx_write/status signals
module pipearch_dma_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int LEN_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          req_grant,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_wvalid,
  output logic [NUM_REQ-1:0]          req_almfull,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        err_overrun,
  output logic                        dma_start,
  output logic [ADDR_W-1:0]           dma_addr,
  output logic [LEN_W-1:0]            dma_len,
  output logic                        dma_we,
  output logic [DATA_W-1:0]           dma_wdata,
  input  logic                        dma_idle,
  input  logic                        dma_done,
  input  logic                        dma_wvalid,
  input  logic                        dma_almfull
);

  localparam int          PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [LEN_W-1:0]   beat_cnt;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [LEN_W-1:0]   len_arr   [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]   = req_len[g*LEN_W +: LEN_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin winner: first valid request scanning upward from rr_ptr.
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  int unsigned       cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NREQ_U) cand = cand - NREQ_U;
      if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  logic busy;
  logic active;
  logic overrun_hit;

  always_comb begin
    busy        = (state != IDLE);
    active      = (state == ACTIVE);
    // Beats in the start cycle are ignored; beats at or past the granted
    // length are dropped and flagged instead of reaching the engine.
    dma_we      = active & req_we[owner] & (beat_cnt < dma_len) & ~dma_start;
    overrun_hit = busy & req_we[owner] & (beat_cnt >= dma_len) & ~dma_start;
    dma_wdata   = active ? wdata_arr[owner] : '0;

    req_wvalid = '0;
    if (busy) req_wvalid[owner] = dma_wvalid;

    if (reset) begin
      req_almfull = '1;
    end else if (busy) begin
      req_almfull        = '1;
      req_almfull[owner] = dma_almfull;
    end else begin
      req_almfull = {NUM_REQ{dma_almfull}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      req_grant   <= '0;
      req_done    <= '0;
      dma_start   <= 1'b0;
      dma_addr    <= '0;
      dma_len     <= '0;
      err_overrun <= 1'b0;
    end else begin
      req_grant <= '0;
      req_done  <= '0;
      dma_start <= 1'b0;

      if (overrun_hit) err_overrun <= 1'b1;
      if (dma_we)      beat_cnt    <= beat_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (dma_idle && win_found) begin
            owner     <= win_idx;
            dma_addr  <= addr_arr[win_idx];
            dma_len   <= len_arr[win_idx];
            dma_start <= 1'b1;
            req_grant <= NUM_REQ'(1) << win_idx;
            beat_cnt  <= '0;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (dma_done) begin
            req_done[owner] <= 1'b1;
            rr_ptr          <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state           <= IDLE;
          end else if ((beat_cnt + LEN_W'(dma_we)) == dma_len) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (dma_done) begin
            req_done[owner] <= 1'b1;
            rr_ptr          <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipearch_dma_write_arbiter.sv
module tb_pipearch_dma_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int LW = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N*AW-1:0]    req_addr = '0;
  logic [N*LW-1:0]    req_len = '0;
  logic [N-1:0]       req_grant;
  logic [N-1:0]       req_we = '0;
  logic [N*DW-1:0]    req_wdata = '0;
  logic [N-1:0]       req_wvalid;
  logic [N-1:0]       req_almfull;
  logic [N-1:0]       req_done;
  logic               err_overrun;
  logic               dma_start;
  logic [AW-1:0]      dma_addr;
  logic [LW-1:0]      dma_len;
  logic               dma_we;
  logic [DW-1:0]      dma_wdata;
  logic               dma_idle = 1'b1;
  logic               dma_done = 1'b0;
  logic               dma_wvalid = 1'b0;
  logic               dma_almfull = 1'b0;

  always #5 clk = ~clk;

  pipearch_dma_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_grant(req_grant), .req_we(req_we), .req_wdata(req_wdata),
    .req_wvalid(req_wvalid), .req_almfull(req_almfull), .req_done(req_done),
    .err_overrun(err_overrun),
    .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_idle(dma_idle), .dma_done(dma_done),
    .dma_wvalid(dma_wvalid), .dma_almfull(dma_almfull)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Transaction-level reference: who owns the engine, how many beats it was
  // granted and has sent, where the round-robin scan starts, pending pulses.
  typedef struct packed {
    bit              busy;
    bit              first;
    bit              err;
    int unsigned     own;
    int unsigned     ptr;
    int unsigned     len;
    int unsigned     beats;
    logic [AW-1:0]   addr;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
  } mstate_t;

  mstate_t m = '0;
  mstate_t n = '0;

  int cnt_we, cnt_start;
  int cnt_wv   [N];
  int cnt_done [N];

  always @(negedge clk) begin
    bit           e_we;
    logic [N-1:0] e_wv, e_af;
    if (reset) begin
      chk("rst_grant",   req_grant,   '0);
      chk("rst_done",    req_done,    '0);
      chk("rst_wvalid",  req_wvalid,  '0);
      chk("rst_almfull", req_almfull, {N{1'b1}});
      chk("rst_start",   dma_start,   '0);
      chk("rst_we",      dma_we,      '0);
      chk("rst_err",     err_overrun, '0);
      chk("rst_addr",    dma_addr,    '0);
      chk("rst_len",     dma_len,     '0);
      chk("rst_wdata",   dma_wdata,   '0);
      m = '0;
      n = '0;
    end else begin
      e_we = m.busy && !m.first && req_we[m.own] && (m.beats < m.len);
      e_wv = m.busy ? (N'(dma_wvalid) << m.own) : '0;
      e_af = m.busy ? (~(N'(1) << m.own) | (N'(dma_almfull) << m.own))
                    : {N{dma_almfull}};
      chk("grant",   req_grant,   m.grant);
      chk("done",    req_done,    m.done);
      chk("start",   dma_start,   m.first);
      chk("addr",    dma_addr,    m.addr);
      chk("len",     dma_len,     m.len);
      chk("we",      dma_we,      e_we);
      chk("wvalid",  req_wvalid,  e_wv);
      chk("almfull", req_almfull, e_af);
      chk("err",     err_overrun, m.err);
      if (e_we) chk("wdata", dma_wdata, req_wdata[m.own*DW +: DW]);

      n       = m;
      n.grant = '0;
      n.done  = '0;
      n.first = 0;
      if (m.busy) begin
        if (e_we) n.beats = m.beats + 1;
        if (req_we[m.own] && !m.first && m.beats >= m.len) n.err = 1;
        if (dma_done) begin
          n.busy = 0;
          n.done = N'(1) << m.own;
          n.ptr  = (m.own + 1) % N;
        end
      end else if (dma_idle && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          int unsigned j;
          j = (m.ptr + k) % N;
          if (!n.busy && req_valid[j]) begin
            n.busy  = 1;
            n.first = 1;
            n.own   = j;
            n.addr  = req_addr[j*AW +: AW];
            n.len   = req_len[j*LW +: LW];
            n.beats = 0;
            n.grant = N'(1) << j;
          end
        end
      end
    end
    cnt_we    += int'(dma_we);
    cnt_start += int'(dma_start);
    for (int i = 0; i < N; i++) begin
      cnt_wv[i]   += int'(req_wvalid[i]);
      cnt_done[i] += int'(req_done[i]);
    end
  end

  always @(posedge clk) m = n;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_we = 0;
    cnt_start = 0;
    for (int i = 0; i < N; i++) begin
      cnt_wv[i] = 0;
      cnt_done[i] = 0;
    end
  endtask

  task automatic quiet_inputs();
    req_valid   = '0;
    req_we      = '0;
    dma_done    = 1'b0;
    dma_wvalid  = 1'b0;
    dma_almfull = 1'b0;
    dma_idle    = 1'b1;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic wait_grant(input string name, output int w);
    w = -1;
    for (int t = 0; t < 20 && w < 0; t++) begin
      cyc();
      for (int i = 0; i < N; i++) if (req_grant[i]) w = i;
    end
    if (w < 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_grant required=grant_within_20_cycles", name);
    end
  endtask

  task automatic finish_xfer();
    dma_done = 1'b1;
    cyc();
    dma_done = 1'b0;
    cyc();
  endtask

  int w;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_wdata = {N{rnd_data()}};
    clear_counts();

    // Single requester, three beats, three acks.
    do_reset();
    clear_counts();
    set_req(2, 42'h100, 32'd3);
    req_valid[2] = 1'b1;
    wait_grant("t1_grant", w);
    req_valid[2] = 1'b0;
    chk("t1_winner", w, 2);
    chk("t1_dma_addr", dma_addr, 42'h100);
    chk("t1_dma_len", dma_len, 3);
    cyc();
    req_we[2] = 1'b1;
    dma_wvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req_wdata[2*DW +: DW] = rnd_data();
      cyc();
    end
    req_we[2] = 1'b0;
    dma_wvalid = 1'b0;
    finish_xfer();
    cyc();
    chk("t1_starts", cnt_start, 1);
    chk("t1_dma_we", cnt_we, 3);
    chk("t1_wvalid2", cnt_wv[2], 3);
    chk("t1_done2", cnt_done[2], 1);
    chk("t1_err", err_overrun, 0);

    // Fairness: everyone requests, each transfer one beat.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(32'h1000 + i), 32'd1);
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      wait_grant("fair_grant", w);
      chk("fair_order", w, exp_order[t]);
      if (w >= 0) begin
        cyc();
        req_we[w] = 1'b1;
        cyc();
        req_we[w] = 1'b0;
      end
      dma_done = 1'b1;
      cyc();
      dma_done = 1'b0;
      if (t == 4) req_valid = '0;
    end
    cyc();

    // Zero length transfer, then rr_ptr must have moved to 2.
    do_reset();
    clear_counts();
    for (int i = 0; i < N; i++) set_req(i, AW'(32'h2000 + i), 32'd0);
    req_valid[1] = 1'b1;
    wait_grant("zl_grant", w);
    req_valid[1] = 1'b0;
    chk("zl_winner", w, 1);
    req_we[1] = 1'b1;
    repeat (2) cyc();
    req_we[1] = 1'b0;
    finish_xfer();
    chk("zl_dma_we", cnt_we, 0);
    chk("zl_done1", cnt_done[1], 1);
    req_valid = '1;
    wait_grant("zl_next_grant", w);
    req_valid = '0;
    chk("zl_rr_ptr", w, 2);
    finish_xfer();

    // Overrun: length 2, three beats; flag survives the next transfer.
    clear_counts();
    set_req(0, 42'h300, 32'd2);
    req_valid[0] = 1'b1;
    wait_grant("ov_grant", w);
    req_valid[0] = 1'b0;
    chk("ov_winner", w, 0);
    cyc();
    req_we[0] = 1'b1;
    repeat (3) cyc();
    req_we[0] = 1'b0;
    chk("ov_dma_we", cnt_we, 2);
    chk("ov_err", err_overrun, 1);
    finish_xfer();
    set_req(3, 42'h400, 32'd1);
    req_valid[3] = 1'b1;
    wait_grant("ov_next_grant", w);
    req_valid[3] = 1'b0;
    cyc();
    req_we[3] = 1'b1;
    cyc();
    req_we[3] = 1'b0;
    finish_xfer();
    chk("ov_err_sticky", err_overrun, 1);

    // Back-pressure and isolation of non-owners.
    do_reset();
    clear_counts();
    set_req(0, 42'h500, 32'd4);
    req_valid[0] = 1'b1;
    wait_grant("bp_grant", w);
    req_valid[0] = 1'b0;
    cyc();
    dma_almfull = 1'b1;
    req_we[3] = 1'b1;
    dma_wvalid = 1'b1;
    #1;
    chk("bp_almfull0", req_almfull[0], 1);
    chk("bp_almfull3", req_almfull[3], 1);
    chk("bp_dma_we", dma_we, 0);
    chk("bp_wvalid3", req_wvalid[3], 0);
    chk("bp_wvalid0", req_wvalid[0], 1);
    repeat (2) cyc();
    chk("bp_cnt_we", cnt_we, 0);
    chk("bp_cnt_wv3", cnt_wv[3], 0);
    dma_almfull = 1'b0;
    req_we[3] = 1'b0;
    dma_wvalid = 1'b0;
    #1;
    chk("bp_almfull0_low", req_almfull[0], 0);
    chk("bp_almfull3_held", req_almfull[3], 1);
    finish_xfer();

    // Reset in the middle of a transfer (rr_ptr is 1 here).
    set_req(1, 42'h600, 32'd4);
    req_valid[1] = 1'b1;
    wait_grant("mr_grant", w);
    req_valid[1] = 1'b0;
    chk("mr_winner", w, 1);
    clear_counts();
    cyc();
    req_we[1] = 1'b1;
    cyc();
    chk("mr_one_beat", cnt_we, 1);
    dma_wvalid = 1'b1;
    reset = 1'b1;
    #1;
    chk("mr_we", dma_we, 0);
    chk("mr_start", dma_start, 0);
    chk("mr_wvalid", req_wvalid, '0);
    chk("mr_almfull", req_almfull, {N{1'b1}});
    chk("mr_addr", dma_addr, 0);
    chk("mr_len", dma_len, 0);
    chk("mr_wdata", dma_wdata, 0);
    repeat (2) cyc();
    quiet_inputs();
    reset = 1'b0;
    repeat (3) cyc();
    chk("mr_no_done", cnt_done[1], 0);
    set_req(2, 42'h700, 32'd1);
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    wait_grant("mr_new_grant", w);
    req_valid[1] = 1'b0;
    chk("mr_new_winner", w, 1);
    chk("mr_new_addr", dma_addr, 42'h600);
    cyc();
    req_we[1] = 1'b1;
    cyc();
    req_we[1] = 1'b0;
    finish_xfer();
    req_valid = '0;
    cyc();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_grant[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          set_req(i, {10'($urandom), 32'($urandom)}, LW'($urandom_range(0, 4)));
          req_valid[i] = 1'b1;
        end
      end
      req_we      = N'($urandom);
      req_wdata   = {rnd_data(), rnd_data(), rnd_data(), rnd_data()};
      dma_idle    = ($urandom_range(0, 3) != 0);
      dma_done    = ($urandom_range(0, 5) == 0);
      dma_wvalid  = $urandom_range(0, 1) == 1;
      dma_almfull = $urandom_range(0, 1) == 1;
      reset       = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    quiet_inputs();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
